// File: rtl/adc_ramp_checker.sv
// adc_ramp_checker
//   Checks both channels of the dual 14-bit ADC interface against fixed-step
//   ramp test patterns, modulo 2^WIDTH, so the ADC data path can be proven
//   bit-exact before real RF samples are used.
//
// Ports
//   clk        in   sample clock
//   rst        in   synchronous, active-high reset
//   enable     in   checker run enable (registered before use)
//   clear      in   synchronous clear of error counters and sticky overflow
//   adc_a      in   channel A sample (WIDTH bits)
//   adc_ovf_a  in   channel A overflow flag
//   adc_b      in   channel B sample (WIDTH bits)
//   adc_ovf_b  in   channel B overflow flag
//   locked     out  both channels tracking the ramp
//   err_a      out  channel A mismatch count, saturating (ERR_WIDTH bits)
//   err_b      out  channel B mismatch count, saturating (ERR_WIDTH bits)
//   ovf_seen   out  sticky overflow on either channel
//   state      out  0 = IDLE, 1 = SYNC, 2 = LOCKED
module adc_ramp_checker #(
    parameter int unsigned WIDTH      = 14,
    parameter int unsigned STEP_A     = 3,
    parameter int unsigned STEP_B     = 16377,
    parameter int unsigned LOCK_COUNT = 16,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     adc_a,
    input  logic                 adc_ovf_a,
    input  logic [WIDTH-1:0]     adc_b,
    input  logic                 adc_ovf_b,
    output logic                 locked,
    output logic [ERR_WIDTH-1:0] err_a,
    output logic [ERR_WIDTH-1:0] err_b,
    output logic                 ovf_seen,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int unsigned GCW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BCW = $clog2(LOSS_COUNT + 1);

    localparam logic [WIDTH-1:0] STEP_A_W = WIDTH'(STEP_A);
    localparam logic [WIDTH-1:0] STEP_B_W = WIDTH'(STEP_B);
    localparam logic [GCW-1:0]   LOCK_W   = GCW'(LOCK_COUNT);
    localparam logic [BCW-1:0]   LOSS_W   = BCW'(LOSS_COUNT);

    // Input stage
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 ovfa_q, ovfb_q, en_q;

    // Compare pipeline and FSM state
    logic [WIDTH-1:0]     prev_a_q, prev_b_q;
    logic                 have_prev_q;
    state_t               state_q;
    logic [GCW-1:0]       good_cnt_q;
    logic [BCW-1:0]       bad_a_q, bad_b_q;
    logic [ERR_WIDTH-1:0] err_a_q, err_b_q;
    logic                 locked_q;
    logic                 ovf_seen_q;

    // Next-value helpers
    logic [WIDTH-1:0]     exp_a, exp_b;
    logic                 cmp, good_a, good_b;
    logic [GCW-1:0]       good_cnt_d;
    logic [BCW-1:0]       bad_a_d, bad_b_d;
    logic [ERR_WIDTH-1:0] err_a_d, err_b_d;

    always_comb begin
        // WIDTH-bit sums: the carry is dropped, giving the modulo-2^WIDTH ramp
        exp_a      = prev_a_q + STEP_A_W;
        exp_b      = prev_b_q + STEP_B_W;
        cmp        = en_q & have_prev_q;
        good_a     = (a_q == exp_a);
        good_b     = (b_q == exp_b);
        good_cnt_d = good_cnt_q + GCW'(1);
        bad_a_d    = good_a ? '0 : bad_a_q + BCW'(1);
        bad_b_d    = good_b ? '0 : bad_b_q + BCW'(1);
        err_a_d    = (&err_a_q) ? err_a_q : err_a_q + ERR_WIDTH'(1);
        err_b_d    = (&err_b_q) ? err_b_q : err_b_q + ERR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            ovfa_q      <= 1'b0;
            ovfb_q      <= 1'b0;
            en_q        <= 1'b0;
            prev_a_q    <= '0;
            prev_b_q    <= '0;
            have_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            good_cnt_q  <= '0;
            bad_a_q     <= '0;
            bad_b_q     <= '0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            locked_q    <= 1'b0;
            ovf_seen_q  <= 1'b0;
        end else begin
            a_q    <= adc_a;
            b_q    <= adc_b;
            ovfa_q <= adc_ovf_a;
            ovfb_q <= adc_ovf_b;
            en_q   <= enable;

            if (!en_q) begin
                state_q     <= ST_IDLE;
                locked_q    <= 1'b0;
                have_prev_q <= 1'b0;
                good_cnt_q  <= '0;
                bad_a_q     <= '0;
                bad_b_q     <= '0;
            end else begin
                // IDLE only arms the checker; the first sample is captured as
                // prev on the first SYNC cycle, giving a 2 + LOCK_COUNT lock
                // latency from the first enabled edge.
                if (state_q != ST_IDLE) begin
                    prev_a_q    <= a_q;
                    prev_b_q    <= b_q;
                    have_prev_q <= 1'b1;
                end

                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (cmp) begin
                            if (good_a && good_b) begin
                                if (good_cnt_d == LOCK_W) begin
                                    state_q    <= ST_LOCKED;
                                    locked_q   <= 1'b1;
                                    good_cnt_q <= '0;
                                end else begin
                                    good_cnt_q <= good_cnt_d;
                                end
                            end else begin
                                good_cnt_q <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (cmp) begin
                            bad_a_q <= bad_a_d;
                            bad_b_q <= bad_b_d;
                            if (!good_a) err_a_q <= err_a_d;
                            if (!good_b) err_b_q <= err_b_d;
                            if ((bad_a_d == LOSS_W) || (bad_b_d == LOSS_W)) begin
                                state_q    <= ST_SYNC;
                                locked_q   <= 1'b0;
                                good_cnt_q <= '0;
                                bad_a_q    <= '0;
                                bad_b_q    <= '0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            if (en_q && (ovfa_q || ovfb_q)) ovf_seen_q <= 1'b1;

            // Placed last so clear overrides a same-edge error increment
            if (clear) begin
                err_a_q    <= '0;
                err_b_q    <= '0;
                ovf_seen_q <= 1'b0;
            end
        end
    end

    assign locked   = locked_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign ovf_seen = ovf_seen_q;
    assign state    = state_q;

endmodule

// File: tb/tb_adc_ramp_checker.sv
// Testbench for adc_ramp_checker: directed scenarios followed by randomized
// traffic. Every cycle the reference model pushes the expected outputs into a
// queue; an independent monitor pops and compares after each clock edge.
// A second instance with a 5-bit error counter exercises saturation.
module tb_adc_ramp_checker;

    localparam int MOD      = 16384;
    localparam int STEP_A   = 3;
    localparam int STEP_B   = 16377;
    localparam int LOCK     = 16;
    localparam int LOSS     = 4;
    localparam int MAX16    = 65535;
    localparam int MAX5     = 31;

    logic        clk;
    logic        rst, enable, clear;
    logic [13:0] adc_a, adc_b;
    logic        adc_ovf_a, adc_ovf_b;
    logic        locked, ovf_seen;
    logic [15:0] err_a, err_b;
    logic [1:0]  state;
    logic        s_locked, s_ovf_seen;
    logic [4:0]  s_err_a, s_err_b;
    logic [1:0]  s_state;

    adc_ramp_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .adc_a(adc_a), .adc_ovf_a(adc_ovf_a), .adc_b(adc_b), .adc_ovf_b(adc_ovf_b),
        .locked(locked), .err_a(err_a), .err_b(err_b), .ovf_seen(ovf_seen), .state(state)
    );

    adc_ramp_checker #(.ERR_WIDTH(5)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .adc_a(adc_a), .adc_ovf_a(adc_ovf_a), .adc_b(adc_b), .adc_ovf_b(adc_ovf_b),
        .locked(s_locked), .err_a(s_err_a), .err_b(s_err_b), .ovf_seen(s_ovf_seen),
        .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit lk;
        int ea;
        int eb;
        bit ov;
        int st;
        int sa;
        int sb;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: behaviour of the checker in terms of samples seen
    int m_pen, m_pa, m_pb, m_povf;      // samples captured by the input stage
    int m_mode;                         // 0 idle, 1 sync, 2 locked
    int m_prev_a, m_prev_b, m_have;
    int m_goods, m_bada, m_badb;
    int m_raw_a, m_raw_b;               // mismatches since last clear/reset
    int m_sticky;

    int ramp_a, ramp_b;

    function automatic int imin(int x, int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit c,
                              input int a, input int b, input bit oa, input bit ob);
        bit ga, gb, do_cmp;
        exp_t x;
        if (r) begin
            m_pen = 0; m_pa = 0; m_pb = 0; m_povf = 0;
            m_mode = 0; m_prev_a = 0; m_prev_b = 0; m_have = 0;
            m_goods = 0; m_bada = 0; m_badb = 0;
            m_raw_a = 0; m_raw_b = 0; m_sticky = 0;
        end else begin
            ga = (m_pa == (m_prev_a + STEP_A) % MOD);
            gb = (m_pb == (m_prev_b + STEP_B) % MOD);
            do_cmp = (m_pen != 0) && (m_have != 0);
            if (m_pen == 0) begin
                m_mode = 0; m_have = 0; m_goods = 0; m_bada = 0; m_badb = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else begin
                if (do_cmp) begin
                    if (m_mode == 1) begin
                        m_goods = (ga && gb) ? m_goods + 1 : 0;
                        if (m_goods == LOCK) begin
                            m_mode = 2;
                            m_goods = 0;
                        end
                    end else begin
                        if (!ga) begin m_raw_a++; m_bada++; end else m_bada = 0;
                        if (!gb) begin m_raw_b++; m_badb++; end else m_badb = 0;
                        if (m_bada >= LOSS || m_badb >= LOSS) begin
                            m_mode = 1; m_goods = 0; m_bada = 0; m_badb = 0;
                        end
                    end
                end
                m_prev_a = m_pa;
                m_prev_b = m_pb;
                m_have = 1;
            end
            if (m_pen != 0 && m_povf != 0) m_sticky = 1;
            if (c) begin
                m_raw_a = 0; m_raw_b = 0; m_sticky = 0;
            end
            m_pen = e; m_pa = a; m_pb = b; m_povf = (oa || ob) ? 1 : 0;
        end
        x.lk = (m_mode == 2);
        x.ea = imin(m_raw_a, MAX16);
        x.eb = imin(m_raw_b, MAX16);
        x.ov = (m_sticky != 0);
        x.st = m_mode;
        x.sa = imin(m_raw_a, MAX5);
        x.sb = imin(m_raw_b, MAX5);
        exp_q.push_back(x);
    endtask

    // One clock: drive inputs, record the expectation for the coming edge
    task automatic step_cycle(input bit r, input bit e, input bit c,
                              input int offa, input int offb, input bit oa, input bit ob);
        int sa, sb;
        sa = (ramp_a + offa) % MOD;
        sb = (ramp_b + offb) % MOD;
        rst = r; enable = e; clear = c;
        adc_a = 14'(sa); adc_b = 14'(sb);
        adc_ovf_a = oa; adc_ovf_b = ob;
        model_step(r, e, c, sa, sb, oa, ob);
        ramp_a = (ramp_a + STEP_A) % MOD;
        ramp_b = (ramp_b + STEP_B) % MOD;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Monitor: compare every edge against the queued expectation
    int mon_cyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (locked !== e.lk || err_a !== 16'(e.ea) || err_b !== 16'(e.eb) ||
                    ovf_seen !== e.ov || state !== 2'(e.st) ||
                    s_err_a !== 5'(e.sa) || s_err_b !== 5'(e.sb)) begin
                    errors++;
                    $display("FAIL outputs@%0d: got lk=%0d ea=%0d eb=%0d ov=%0d st=%0d sa=%0d sb=%0d want lk=%0d ea=%0d eb=%0d ov=%0d st=%0d sa=%0d sb=%0d",
                             mon_cyc, locked, err_a, err_b, ovf_seen, state, s_err_a, s_err_b,
                             e.lk, e.ea, e.eb, e.ov, e.st, e.sa, e.sb);
                end
            end
        end
    end

    initial begin
        int lock_edge;
        int acc;
        bit en_r;
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        adc_a = '0; adc_b = '0; adc_ovf_a = 1'b0; adc_ovf_b = 1'b0;
        ramp_a = 0; ramp_b = 0;

        // Reset
        for (int i = 0; i < 3; i++) step_cycle(1, 0, 0, 0, 0, 0, 0);
        check("rst_state", int'(state), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err_a", int'(err_a), 0);
        check("rst_ovf", int'(ovf_seen), 0);

        // Clean ramp: lock latency and error-free run
        ramp_a = 0; ramp_b = 0;
        lock_edge = -1;
        for (int k = 0; k < 1000; k++) begin
            step_cycle(0, 1, 0, 0, 0, 0, 0);
            if (lock_edge < 0 && locked === 1'b1) lock_edge = k;
        end
        check("lock_edge", lock_edge, 18);
        check("clean_err_a", int'(err_a), 0);
        check("clean_err_b", int'(err_b), 0);

        // Wrap-around on both channels across the compare window
        for (int i = 0; i < 2; i++) step_cycle(0, 0, 0, 0, 0, 0, 0);
        ramp_a = 16377; ramp_b = 12;
        run(40);
        check("wrap_locked", int'(locked), 1);
        check("wrap_err_a", int'(err_a), 0);
        check("wrap_err_b", int'(err_b), 0);

        // Single glitch on A counts twice
        step_cycle(0, 1, 0, 1, 0, 0, 0);
        run(10);
        check("glitch_err_a", int'(err_a), 2);
        check("glitch_err_b", int'(err_b), 0);
        check("glitch_locked", int'(locked), 1);

        // Four corrupted B samples drop lock
        step_cycle(0, 1, 0, 0, 100, 0, 0);
        step_cycle(0, 1, 0, 0, 200, 0, 0);
        step_cycle(0, 1, 0, 0, 300, 0, 0);
        step_cycle(0, 1, 0, 0, 400, 0, 0);
        step_cycle(0, 1, 0, 0, 0, 0, 0);
        check("loss_state", int'(state), 1);
        check("loss_locked", int'(locked), 0);
        check("loss_err_b", int'(err_b), 4);
        step_cycle(0, 1, 0, 0, 0, 0, 0);
        check("sync_err_b_hold", int'(err_b), 4);
        run(15);
        check("relock_early", int'(locked), 0);
        run(1);
        check("relock", int'(locked), 1);

        // Sticky overflow, then clear colliding with an A error
        step_cycle(0, 1, 0, 0, 0, 1, 0);
        run(2);
        check("ovf_set", int'(ovf_seen), 1);
        run(5);
        check("ovf_sticky", int'(ovf_seen), 1);
        step_cycle(0, 1, 0, 5, 0, 0, 0);
        step_cycle(0, 1, 1, 0, 0, 0, 0);
        check("clear_err_a", int'(err_a), 0);
        check("clear_ovf", int'(ovf_seen), 0);
        check("clear_state", int'(state), 2);
        step_cycle(0, 1, 0, 0, 0, 0, 0);

        // Enable drop while locked: counters hold
        step_cycle(0, 0, 0, 0, 0, 0, 0);
        step_cycle(0, 0, 0, 0, 0, 0, 0);
        check("endrop_state", int'(state), 0);
        check("endrop_locked", int'(locked), 0);
        check("endrop_err_a", int'(err_a), 1);

        // Reset in the middle of SYNC
        run(6);
        check("presync_state", int'(state), 1);
        step_cycle(1, 1, 0, 0, 0, 0, 0);
        check("midrst_state", int'(state), 0);
        check("midrst_err_a", int'(err_a), 0);
        check("midrst_ovf", int'(ovf_seen), 0);
        lock_edge = -1;
        for (int k = 0; k < 25; k++) begin
            step_cycle(0, 1, 0, 0, 0, 0, 0);
            if (lock_edge < 0 && locked === 1'b1) lock_edge = k;
        end
        check("lock_edge_after_rst", lock_edge, 18);

        // Saturation: three bad compares then one good, repeatedly, keeps lock
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc++;
                step_cycle(0, 1, 0, acc, 0, 0, 0);
            end
            step_cycle(0, 1, 0, acc, 0, 0, 0);
        end
        check("sat_err_a_small", int'(s_err_a), MAX5);
        check("sat_err_a_wide", int'(err_a), 60);
        check("sat_locked", int'(locked), 1);

        // Randomized traffic
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit r, c, oa, ob;
            int offa, offb;
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            r    = ($urandom_range(0, 999) < 3);
            c    = ($urandom_range(0, 149) == 0);
            oa   = ($urandom_range(0, 299) == 0);
            ob   = ($urandom_range(0, 299) == 0);
            offa = ($urandom_range(0, 99) < 3) ? int'($urandom_range(1, 50)) : 0;
            offb = ($urandom_range(0, 99) < 3) ? int'($urandom_range(1, 50)) : 0;
            step_cycle(r, en_r, c, offa, offb, oa, ob);
        end

        step_cycle(0, 0, 0, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
